// File: rtl/muldiv_pkg.sv
// Shared types and constants for the multiply/divide sequencer.
// The main control FSM also uses the op constants.
package muldiv_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WAIT  = 3'd2,
    S_WRITE = 3'd3,
    S_EXC   = 3'd4
  } state_e;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'd0,
    CAUSE_DIV_ZERO = 2'd1,
    CAUSE_TIMEOUT  = 2'd2
  } cause_e;

endpackage

// File: rtl/muldiv_watchdog.sv
// Wait-cycle counter for the mult/div sequencer.
// `expired` is registered and is high while the count equals TIMEOUT.
module muldiv_watchdog #(
  parameter int unsigned TIMEOUT = 40,
  parameter int unsigned CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             expired
);

  logic [CNT_W-1:0] count_q, count_d;
  logic             expired_q, expired_d;

  // Clear wins over enable; the sequencer leaves WAIT at TIMEOUT, so no wrap.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + CNT_W'(1);
    end
    expired_d = (count_d == CNT_W'(TIMEOUT));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q   <= '0;
      expired_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      expired_q <= expired_d;
    end
  end

  assign count   = count_q;
  assign expired = expired_q;

endmodule

// File: rtl/muldiv_ctrl.sv
// Sequencer for the shared mult/div resource: start pulse, watchdogged wait,
// then HI/LO load or a div-zero/timeout exception.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int unsigned TIMEOUT = 40,
  parameter int unsigned CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic             op,
  input  logic             abort,
  input  logic             mult_end,
  input  logic             div_end,
  input  logic             div_zero,
  output logic             mult_start,
  output logic             div_start,
  output logic             hi_ctrl,
  output logic             lo_ctrl,
  output logic             hilo_write,
  output logic             busy,
  output logic             done,
  output logic             exc_div_zero,
  output logic             exc_timeout,
  output logic [CNT_W-1:0] last_cycles
);

  state_e           state_q, state_d;
  logic             op_q, op_d;
  cause_e           cause_q, cause_d;
  logic [CNT_W-1:0] last_q, last_d;

  logic             busy_q, busy_d;
  logic             mult_start_q, mult_start_d;
  logic             div_start_q, div_start_d;
  logic             hilo_sel_q, hilo_sel_d;
  logic             hilo_write_q, hilo_write_d;
  logic             done_q, done_d;
  logic             exc_dz_q, exc_dz_d;
  logic             exc_to_q, exc_to_d;

  logic             wd_clear;
  logic             wd_enable;
  logic [CNT_W-1:0] wd_count;
  logic             wd_expired;
  logic             end_sel;

  muldiv_watchdog #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .count   (wd_count),
    .expired (wd_expired)
  );

  assign end_sel = (op_q == OP_DIV) ? div_end : mult_end;

  // Next state; outputs are decoded from the next state so they register in step with it.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cause_d  = cause_q;
    last_d   = last_q;
    wd_clear = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          op_d     = op;
          wd_clear = 1'b1;
          state_d  = S_START;
        end
      end
      S_START: begin
        if (abort) begin
          last_d  = wd_count;
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (abort) begin
          last_d  = wd_count;
          state_d = S_IDLE;
        end else if ((op_q == OP_DIV) && div_zero) begin
          last_d  = wd_count;
          cause_d = CAUSE_DIV_ZERO;
          state_d = S_EXC;
        end else if (end_sel) begin
          last_d  = wd_count;
          state_d = S_WRITE;
        end else if (wd_expired) begin
          last_d  = wd_count;
          cause_d = CAUSE_TIMEOUT;
          state_d = S_EXC;
        end
      end
      S_WRITE: state_d = S_IDLE;
      S_EXC:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    wd_enable    = (state_d == S_WAIT);

    busy_d       = (state_d != S_IDLE);
    mult_start_d = (state_d == S_START) && (op_d == OP_MULT);
    div_start_d  = (state_d == S_START) && (op_d == OP_DIV);
    hilo_sel_d   = (state_d != S_IDLE) ? op_d : 1'b0;
    hilo_write_d = (state_d == S_WRITE);
    done_d       = (state_d == S_WRITE) || (state_d == S_EXC);
    exc_dz_d     = (state_d == S_EXC) && (cause_d == CAUSE_DIV_ZERO);
    exc_to_d     = (state_d == S_EXC) && (cause_d == CAUSE_TIMEOUT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      op_q         <= OP_MULT;
      cause_q      <= CAUSE_NONE;
      last_q       <= '0;
      busy_q       <= 1'b0;
      mult_start_q <= 1'b0;
      div_start_q  <= 1'b0;
      hilo_sel_q   <= 1'b0;
      hilo_write_q <= 1'b0;
      done_q       <= 1'b0;
      exc_dz_q     <= 1'b0;
      exc_to_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      cause_q      <= cause_d;
      last_q       <= last_d;
      busy_q       <= busy_d;
      mult_start_q <= mult_start_d;
      div_start_q  <= div_start_d;
      hilo_sel_q   <= hilo_sel_d;
      hilo_write_q <= hilo_write_d;
      done_q       <= done_d;
      exc_dz_q     <= exc_dz_d;
      exc_to_q     <= exc_to_d;
    end
  end

  assign mult_start   = mult_start_q;
  assign div_start    = div_start_q;
  assign hi_ctrl      = hilo_sel_q;
  assign lo_ctrl      = hilo_sel_q;
  assign hilo_write   = hilo_write_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign exc_div_zero = exc_dz_q;
  assign exc_timeout  = exc_to_q;
  assign last_cycles  = last_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Randomized self-checking bench for muldiv_ctrl against a per-operation outcome model.
module tb_muldiv_ctrl;

  localparam int unsigned TIMEOUT = 40;
  localparam int unsigned CNT_W   = $clog2(TIMEOUT + 1);

  localparam int K_WRITE = 0;
  localparam int K_DZ    = 1;
  localparam int K_TO    = 2;
  localparam int K_ABORT = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             req, op, abort, mult_end, div_end, div_zero;
  logic             mult_start, div_start, hi_ctrl, lo_ctrl, hilo_write;
  logic             busy, done, exc_div_zero, exc_timeout;
  logic [CNT_W-1:0] last_cycles;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  muldiv_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .op           (op),
    .abort        (abort),
    .mult_end     (mult_end),
    .div_end      (div_end),
    .div_zero     (div_zero),
    .mult_start   (mult_start),
    .div_start    (div_start),
    .hi_ctrl      (hi_ctrl),
    .lo_ctrl      (lo_ctrl),
    .hilo_write   (hilo_write),
    .busy         (busy),
    .done         (done),
    .exc_div_zero (exc_div_zero),
    .exc_timeout  (exc_timeout),
    .last_cycles  (last_cycles)
  );

  task automatic check(input string tag, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req = 0; op = 0; abort = 0; mult_end = 0; div_end = 0; div_zero = 0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_starts"}, {mult_start, div_start}, 0);
    check({tag, "_hilo"}, {hi_ctrl, lo_ctrl, hilo_write}, 0);
    check({tag, "_done"}, {done, exc_div_zero, exc_timeout}, 0);
  endtask

  // Outcome of one operation: walk the WAIT cycles applying the priority rules.
  function automatic void model(input bit mop, input int end_at, input int dz_at,
                                input int abort_at, output int kind, output int last);
    kind = K_TO;
    last = TIMEOUT;
    for (int k = 1; k <= TIMEOUT; k++) begin
      if (abort_at == k) begin kind = K_ABORT; last = k; return; end
      if (mop && dz_at == k) begin kind = K_DZ; last = k; return; end
      if (end_at == k) begin kind = K_WRITE; last = k; return; end
    end
  endfunction

  // One request from IDLE to IDLE; *_at give the WAIT cycle (1-based) of each event, 0 = never.
  task automatic run_op(input string tag, input bit mop, input int end_at, input int dz_at,
                        input int abort_at, input int stray_at, input bit req_busy);
    int kind, last, k, ms, ds;
    bit fin;
    model(mop, end_at, dz_at, abort_at, kind, last);
    req = 1; op = mop;
    tick();
    check({tag, "_start_busy"}, busy, 1);
    ms = mult_start; ds = div_start;
    req = req_busy; op = ~mop;
    tick();
    k = 1; fin = 0;
    while (!fin) begin
      if (k > TIMEOUT + 2) begin
        check({tag, "_wait_bound"}, k, last);
        break;
      end
      check({tag, "_wait_busy"}, busy, 1);
      check({tag, "_wait_done"}, done, 0);
      ms += mult_start; ds += div_start;
      abort    = (abort_at == k);
      div_zero = (dz_at == k);
      mult_end = mop ? (stray_at == k) : (end_at == k);
      div_end  = mop ? (end_at == k) : (stray_at == k);
      tick();
      clear_inputs();
      ms += mult_start; ds += div_start;
      if (done || !busy) fin = 1;
      else k++;
    end
    check({tag, "_wait_len"}, k, last);
    check({tag, "_mult_start_cnt"}, ms, mop ? 0 : 1);
    check({tag, "_div_start_cnt"}, ds, mop ? 1 : 0);
    check({tag, "_last_cycles"}, last_cycles, last);
    check({tag, "_done"}, done, (kind != K_ABORT));
    check({tag, "_hilo_write"}, hilo_write, (kind == K_WRITE));
    check({tag, "_exc_dz"}, exc_div_zero, (kind == K_DZ));
    check({tag, "_exc_to"}, exc_timeout, (kind == K_TO));
    if (kind != K_ABORT) begin
      check({tag, "_hilo_sel"}, {hi_ctrl, lo_ctrl}, mop ? 3 : 0);
      check({tag, "_busy_end"}, busy, 1);
      tick();
    end
    check_idle_outputs({tag, "_idle"});
  endtask

  initial begin
    clear_inputs();
    rst = 0;
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    check("reset_last", last_cycles, 0);
    rst = 1;
    tick();

    run_op("mult33", 0, 33, 0, 0, 0, 0);
    run_op("div5", 1, 5, 0, 0, 3, 0);
    run_op("div_zero2", 1, 2, 2, 0, 0, 0);
    run_op("timeout", 0, 0, 0, 0, 0, 0);
    run_op("end_at_to", 0, TIMEOUT, 0, 0, 0, 0);
    run_op("abort3", 1, 10, 0, 3, 0, 1);
    run_op("mult_min", 0, 1, 1, 0, 0, 1);

    // Asynchronous reset during WAIT.
    req = 1; op = 0;
    tick();
    clear_inputs();
    repeat (4) tick();
    #2 rst = 0;
    #1;
    check_idle_outputs("rst_mid");
    check("rst_mid_last", last_cycles, 0);
    mult_end = 1;
    tick();
    check("rst_hold_hilo", hilo_write, 0);
    clear_inputs();
    rst = 1;
    tick();
    run_op("after_rst", 0, 7, 0, 0, 0, 0);

    for (int i = 0; i < 30; i++) begin
      bit mop;
      int e, dz, ab;
      mop = 1'($urandom_range(0, 1));
      e   = $urandom_range(1, TIMEOUT + 4);
      dz  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, TIMEOUT) : 0;
      ab  = ($urandom_range(0, 5) == 0) ? $urandom_range(1, TIMEOUT) : 0;
      run_op("rand", mop, e, dz, ab, $urandom_range(1, TIMEOUT), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
